// File: rtl/fn_sw_deser_pkg.sv
// Shared definitions for the function-switch deserializer: FSM encoding and default width.
package fn_sw_deser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int FN_SW_W = 8;

endpackage

// File: rtl/fn_sw_popcnt.sv
// Combinational ones-count of a W-bit vector; also used by the word-level checker.
module fn_sw_popcnt #(
  parameter int W = 8
) (
  input  logic [W-1:0]           data_i,
  output logic [$clog2(W+1)-1:0] ones_o
);

  localparam int OW = $clog2(W+1);

  always_comb begin
    ones_o = '0;
    for (int i = 0; i < W; i++) begin
      ones_o = ones_o + {{(OW-1){1'b0}}, data_i[i]};
    end
  end

endmodule

// File: rtl/fn_sw_deser.sv
// Packs framed serial bits from the function switch into W-bit words with length and
// ones-count, presented on a registered valid/ready output.
module fn_sw_deser
  import fn_sw_deser_pkg::*;
#(
  parameter int W         = FN_SW_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bit_in,
  input  logic                   bit_vld,
  input  logic                   bit_sof,
  input  logic                   bit_eof,
  output logic                   bit_rdy,
  output logic [W-1:0]           word_out,
  output logic [$clog2(W+1)-1:0] word_len,
  output logic [$clog2(W+1)-1:0] word_ones,
  output logic                   word_vld,
  input  logic                   word_rdy,
  output logic                   frame_err
);

  localparam int CW = $clog2(W);
  localparam int LW = $clog2(W+1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   sh_q, sh_d;
  logic [W-1:0]   word_q, word_d;
  logic [LW-1:0]  len_q, len_d;
  logic [LW-1:0]  ones_q, ones_d;
  logic           vld_q, vld_d;
  logic           err_q, err_d;

  logic           completing, accept, done;
  logic [CW-1:0]  pos, idx;
  logic [W-1:0]   base, nxt;
  logic [LW-1:0]  nxt_ones;

  assign completing = (state_q == SHIFT && (cnt_q == CW'(W-1) || bit_eof)) ||
                      (state_q == IDLE && bit_sof && bit_eof);
  assign bit_rdy    = ~(vld_q & ~word_rdy & completing);
  assign accept     = bit_vld & bit_rdy;

  // A sof bit always restarts at position 0, discarding whatever partial word exists.
  assign pos  = bit_sof ? '0 : cnt_q;
  assign base = bit_sof ? '0 : sh_q;
  assign idx  = MSB_FIRST ? (CW'(W-1) - pos) : pos;
  assign done = (pos == CW'(W-1)) || bit_eof;

  always_comb begin
    nxt      = base;
    nxt[idx] = bit_in;
  end

  fn_sw_popcnt #(.W(W)) u_popcnt (
    .data_i (nxt),
    .ones_o (nxt_ones)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    word_d  = word_q;
    len_d   = len_q;
    ones_d  = ones_q;
    vld_d   = vld_q;
    err_d   = 1'b0;
    if (vld_q && word_rdy) vld_d = 1'b0;
    if (accept) begin
      if (state_q == IDLE && !bit_sof) begin
        err_d = 1'b1;
      end else begin
        if (state_q == SHIFT && bit_sof && cnt_q != '0) err_d = 1'b1;
        if (done) begin
          word_d  = nxt;
          len_d   = LW'(pos) + LW'(1);
          ones_d  = nxt_ones;
          vld_d   = 1'b1;
          cnt_d   = '0;
          sh_d    = '0;
          state_d = bit_eof ? IDLE : SHIFT;
        end else begin
          sh_d    = nxt;
          cnt_d   = pos + CW'(1);
          state_d = SHIFT;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      word_q  <= '0;
      len_q   <= '0;
      ones_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      word_q  <= word_d;
      len_q   <= len_d;
      ones_q  <= ones_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign word_out  = word_q;
  assign word_len  = len_q;
  assign word_ones = ones_q;
  assign word_vld  = vld_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_fn_sw_deser.sv
// Self-checking bench for fn_sw_deser: directed vector table, hand sequences for
// reset/backpressure/function-switch integration, and a randomized run against a queue model.
module tb_fn_sw_deser;

  localparam int W  = 8;
  localparam int LW = $clog2(W+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bit_in = 1'b0, bit_vld = 1'b0, bit_sof = 1'b0, bit_eof = 1'b0;
  logic          word_rdy = 1'b1;
  logic          bit_rdy, bit_rdy0;
  logic [W-1:0]  word_out, word_out0;
  logic [LW-1:0] word_len, word_len0, word_ones, word_ones0;
  logic          word_vld, word_vld0, frame_err, frame_err0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fn_sw_deser #(.W(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld), .bit_sof(bit_sof),
    .bit_eof(bit_eof), .bit_rdy(bit_rdy), .word_out(word_out), .word_len(word_len),
    .word_ones(word_ones), .word_vld(word_vld), .word_rdy(word_rdy), .frame_err(frame_err)
  );

  fn_sw_deser #(.W(W), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld), .bit_sof(bit_sof),
    .bit_eof(bit_eof), .bit_rdy(bit_rdy0), .word_out(word_out0), .word_len(word_len0),
    .word_ones(word_ones0), .word_vld(word_vld0), .word_rdy(word_rdy), .frame_err(frame_err0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic b, input logic s, input logic e);
    bit_in = b; bit_sof = s; bit_eof = e; bit_vld = 1'b1;
  endtask

  task automatic idle();
    bit_vld = 1'b0; bit_sof = 1'b0; bit_eof = 1'b0; bit_in = 1'b0;
  endtask

  function automatic logic fsw(input logic a, input logic b, input logic sel);
    return sel ? a : b;
  endfunction

  typedef struct {
    logic       b, sof, eof, err, ld;
    logic [7:0] w1, w0;
    logic [3:0] len, ones;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic b, logic s, logic e, logic err, logic ld,
                              logic [7:0] w1, logic [7:0] w0, logic [3:0] len, logic [3:0] ones);
    vec_t v;
    v.b = b; v.sof = s; v.eof = e; v.err = err; v.ld = ld;
    v.w1 = w1; v.w0 = w0; v.len = len; v.ones = ones;
    return v;
  endfunction

  // Reference model state: bits of the word in progress and the expected output register.
  bit         m_in_frame;
  bit         m_bits[$];
  bit         m_vld, m_err;
  logic [7:0] m_w1, m_w0;
  int         m_len, m_ones;

  task automatic model_reset();
    m_in_frame = 0; m_bits.delete(); m_vld = 0; m_err = 0;
    m_w1 = '0; m_w0 = '0; m_len = 0; m_ones = 0;
  endtask

  initial begin
    logic [7:0] pat;
    logic       a, b, sel, exp_rdy, acc, xfer, ld;

    // Reset values held while rst is asserted
    repeat (2) @(negedge clk);
    chk("rst_vld", 32'(word_vld), 0);
    chk("rst_word", 32'(word_out), 0);
    chk("rst_len", 32'(word_len), 0);
    chk("rst_ones", 32'(word_ones), 0);
    chk("rst_err", 32'(frame_err), 0);
    rst = 1'b0;
    #1 chk("rst_rdy", 32'(bit_rdy), 1);

    // Directed vector table, word_rdy=1
    pat = 8'hB2;
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(pat[7-i], i == 0, i == 7, 0, i == 7, 8'hB2, 8'h4D, 8, 4));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 8'hE0, 8'h07, 3, 3));
    pat = 8'b10101;
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(pat[4-i], i == 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, i == 0, i == 7, i == 0, i == 7, 8'hFF, 8'hFF, 8, 8));
    tbl.push_back(mk(1, 1, 1, 0, 1, 8'h80, 8'h01, 1, 1));

    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].b, tbl[i].sof, tbl[i].eof);
      @(negedge clk);
      chk($sformatf("tbl%0d_err", i), 32'(frame_err), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_vld", i), 32'(word_vld), 32'(tbl[i].ld));
      if (tbl[i].ld) begin
        chk($sformatf("tbl%0d_word", i), 32'(word_out), 32'(tbl[i].w1));
        chk($sformatf("tbl%0d_word0", i), 32'(word_out0), 32'(tbl[i].w0));
        chk($sformatf("tbl%0d_len", i), 32'(word_len), 32'(tbl[i].len));
        chk($sformatf("tbl%0d_ones", i), 32'(word_ones), 32'(tbl[i].ones));
      end
    end
    idle();
    @(negedge clk);
    chk("tbl_vld_drop", 32'(word_vld), 0);

    // Backpressure: 16-bit frame B2,5A with word_rdy low
    word_rdy = 1'b0;
    for (int i = 0; i < 15; i++) begin
      pat = (i < 8) ? 8'hB2 : 8'h5A;
      drive(pat[7 - (i % 8)], i == 0, 0);
      @(negedge clk);
    end
    drive(1'b0, 0, 1);
    #1 chk("bp_rdy_low", 32'(bit_rdy), 0);
    repeat (2) @(negedge clk);
    chk("bp_hold_vld", 32'(word_vld), 1);
    chk("bp_hold_word", 32'(word_out), 32'hB2);
    word_rdy = 1'b1;
    #1 chk("bp_rdy_high", 32'(bit_rdy), 1);
    @(negedge clk);
    idle();
    chk("bp_second_vld", 32'(word_vld), 1);
    chk("bp_second_word", 32'(word_out), 32'h5A);
    chk("bp_second_ones", 32'(word_ones), 4);
    chk("bp_second_len", 32'(word_len), 8);
    @(negedge clk);
    chk("bp_drain", 32'(word_vld), 0);

    // Function-switch integration: y = 1,1,0,0,1,1,0,0
    pat = 8'hCC;
    for (int i = 0; i < 8; i++) begin
      sel = pat[7-i]; a = pat[7-i]; b = 1'b0;
      drive(fsw(a, b, sel), i == 0, i == 7);
      @(negedge clk);
    end
    idle();
    chk("fsw_vld", 32'(word_vld), 1);
    chk("fsw_word", 32'(word_out), 32'hCC);
    chk("fsw_word0", 32'(word_out0), 32'h33);
    chk("fsw_ones", 32'(word_ones), 4);
    @(negedge clk);

    // Reset mid-traffic with a pending word and a partial frame
    word_rdy = 1'b0;
    pat = 8'hB2;
    for (int i = 0; i < 11; i++) begin
      drive(pat[7 - (i % 8)], i == 0 || i == 8, i == 7);
      @(negedge clk);
    end
    idle();
    chk("pre_rst_vld", 32'(word_vld), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", 32'(word_vld), 0);
    chk("mid_rst_word", 32'(word_out), 0);
    chk("mid_rst_word0", 32'(word_out0), 0);
    chk("mid_rst_err", 32'(frame_err), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_rdy", 32'(bit_rdy), 1);
    word_rdy = 1'b1;
    @(negedge clk);
    drive(1'b1, 0, 0);
    @(negedge clk);
    idle();
    chk("post_rst_idle_err", 32'(frame_err), 1);
    chk("post_rst_no_word", 32'(word_vld), 0);
    @(negedge clk);

    // Randomized traffic against the queue model
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_err", 32'(frame_err), 32'(m_err));
      chk("rnd_err0", 32'(frame_err0), 32'(m_err));
      chk("rnd_vld", 32'(word_vld), 32'(m_vld));
      if (m_vld) begin
        chk("rnd_word", 32'(word_out), 32'(m_w1));
        chk("rnd_word0", 32'(word_out0), 32'(m_w0));
        chk("rnd_len", 32'(word_len), 32'(m_len));
        chk("rnd_ones", 32'(word_ones), 32'(m_ones));
      end
      bit_vld  = ($urandom_range(3) != 0);
      bit_in   = $urandom_range(1);
      bit_sof  = ($urandom_range(15) == 0) || (!m_in_frame && $urandom_range(1) == 1);
      bit_eof  = ($urandom_range(9) == 0);
      word_rdy = ($urandom_range(3) != 0);
      #1;
      exp_rdy = !(m_vld && !word_rdy &&
                  ((m_in_frame && (m_bits.size() == W-1 || bit_eof)) ||
                   (!m_in_frame && bit_sof && bit_eof)));
      chk("rnd_rdy", 32'(bit_rdy), 32'(exp_rdy));
      chk("rnd_rdy0", 32'(bit_rdy0), 32'(exp_rdy));
      acc  = bit_vld && exp_rdy;
      xfer = m_vld && word_rdy;
      ld   = 1'b0;
      m_err = 0;
      if (acc) begin
        if (!m_in_frame && !bit_sof) begin
          m_err = 1;
        end else begin
          if (m_in_frame && bit_sof && m_bits.size() != 0) m_err = 1;
          if (bit_sof) m_bits.delete();
          m_in_frame = 1;
          m_bits.push_back(bit_in);
          if (m_bits.size() == W || bit_eof) begin
            m_w1 = '0; m_w0 = '0; m_ones = 0;
            foreach (m_bits[k]) begin
              m_w1[W-1-k] = m_bits[k];
              m_w0[k]     = m_bits[k];
              m_ones     += int'(m_bits[k]);
            end
            m_len = m_bits.size();
            m_bits.delete();
            ld = 1'b1;
            if (bit_eof) m_in_frame = 0;
          end
        end
      end
      m_vld = ld ? 1'b1 : (xfer ? 1'b0 : m_vld);
      @(negedge clk);
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fn_sw_deser.md
Name: fn_sw_deser

Overview:
- Downstream consumer of the function-switch stage. Takes the serial result bit `y` with a valid/ready handshake and a sof/eof frame delimiter.
- Packs the bits into W-bit words.
- Presents each word with its ones-count and bit length on a registered valid/ready output.
- Feeds the word-level logic that checks the function-switch output.

Parameters:
- W, 8, word width in bits, ≥2.
- MSB_FIRST, 1, 1: first bit of a word lands in word_out[W-1]; 0: first bit lands in word_out[0].

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- bit_in  in  1  serial data bit (function-switch `y` output).
- bit_vld  in  1  bit_in valid.
- bit_sof  in  1  first bit of frame; qualified by bit_vld.
- bit_eof  in  1  last bit of frame; qualified by bit_vld.
- bit_rdy  out  1  block accepts a bit this cycle.
- word_out  out  W  packed word; unfilled positions are 0.
- word_len  out  $clog2(W+1)  number of valid bits in word_out, 1..W.
- word_ones  out  $clog2(W+1)  popcount of word_out.
- word_vld  out  1  output word valid.
- word_rdy  in  1  consumer takes the word.
- frame_err  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-high.
- On rst=1, immediately:
  - word_out=0, word_len=0, word_ones=0, word_vld=0, frame_err=0.
  - Bit counter cnt=0, shift register=0, FSM=IDLE.
  - bit_rdy=1 as soon as rst=0.
  - Reset mid-frame discards the partial word and any pending output word.
- Bit accept: a bit is accepted when bit_vld & bit_rdy. Output transfer: when word_vld & word_rdy.
- FSM IDLE:
  - Accepted bit with sof=0: dropped; frame_err pulses next cycle.
  - Accepted bit with sof=1: goes to bit position 0, cnt=1, go to SHIFT.
- FSM SHIFT:
  - Each accepted bit is placed at position cnt and cnt increments.
  - Position mapping: MSB_FIRST=1 gives index W-1-cnt, else index cnt.
- Word completion (accepted bit with cnt==W-1, or any accepted bit with eof=1):
  - Next edge: word_out, word_len=cnt+1 and word_ones load; word_vld=1; cnt=0; shift register clears.
  - With eof=1: FSM goes to IDLE. Otherwise the FSM stays in SHIFT, the frame continues, and the next word needs no sof.
- Latency: word_vld rises exactly one cycle after the completing bit is accepted.
- sof=1 in SHIFT:
  - If cnt≠0: partial word discarded, frame_err pulses next cycle, and the bit restarts a word at position 0 (cnt=1).
  - If cnt==0: legal, no error.
- sof=1 and eof=1 on the same bit: single-bit frame emitted with word_len=1; no error.
- Output register:
  - word_vld holds, and word_* stay stable, until a transfer occurs.
  - A new word may load in the same cycle as a transfer, so back-to-back words reach one word per W cycles with no bubble.
- Backpressure (combinational on word_rdy):
  - bit_rdy = ~(word_vld & ~word_rdy & completing), where completing = (FSM==SHIFT & (cnt==W-1 | bit_eof)) | (FSM==IDLE & bit_sof & bit_eof).
  - Non-completing bits are always accepted.
  - No bit is ever lost or overwritten.
- word_ones: popcount of the masked word, computed combinationally from the next-word value and registered with word_out.
- Widths: cnt is $clog2(W) bits and never exceeds W-1; no wrap beyond W.

Decomposition:
- Shared include fn_sw_defs.vh:
  - FSM state localparams IDLE=1'b0, SHIFT=1'b1.
  - Default word width localparam FN_SW_W=8.
- Sub-module fn_sw_popcnt (parameter W): combinational popcount, W-bit input, $clog2(W+1)-bit output. Reused by the checker.

Test Plan:
- Reset: rst=1 for 3 cycles mid-traffic → word_vld=0, word_out=0, frame_err=0 at once; bit_rdy=1 after release.
- Full word, W=8, MSB_FIRST=1, word_rdy=1: bits 1,0,1,1,0,0,1,0 with sof on bit 1 and eof on bit 8 → one cycle later word_out=8'hB2, word_len=8, word_ones=4, word_vld=1 for one cycle; FSM back in IDLE.
- Backpressure: 16-bit frame 8'hB2 then 8'h5A, word_rdy=0:
  - bit_rdy drops while the 16th bit is presented.
  - Raise word_rdy → 8'hB2 transfers, then 8'h5A (ones=4) one cycle later, no loss.
- Partial word: sof on bit 1, bits 1,1,1 with eof on bit 3 → word_out=8'hE0, word_len=3, word_ones=3.
- Framing errors:
  - Two sof=0 bits in IDLE → two frame_err pulses, no word.
  - sof after 5 bits in SHIFT → frame_err pulse; next 8 bits 8'hFF with eof → word_out=8'hFF, word_ones=8.
- Integration with function switch: drive a,b,sel so that y = 1,1,0,0,1,1,0,0 (sof first, eof last), e.g. sel=1 with a=1,b=0 for y=1 and sel=0 with a=0,b=0 for y=0 → word_out=8'hCC, word_ones=4; MSB_FIRST=0 → word_out=8'h33.
